// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, 50% duty for odd and even ratios.
// Ratio and enable are only acted upon at period boundaries.
module clk_div_prog #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEF_N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div_n,
  output logic         div_clk,
  output logic         div_tick,
  output logic [W-1:0] cur_div,
  output logic         running,
  output logic         clamp
);

  localparam logic [0:0]   S_IDLE = 1'b0;
  localparam logic [0:0]   S_RUN  = 1'b1;
  localparam logic [W-1:0] DEF    = W'(DEF_N);
  localparam logic [W-1:0] MIN_N  = W'(2);

  logic [0:0]   r_state;
  logic [W-1:0] r_cnt;
  logic         r_q_pos;
  logic         r_q_neg;
  logic         r_tick;
  logic [W-1:0] r_cur_div;
  logic         r_clamp;
  logic         r_odd;

  logic [W-1:0] w_half;
  logic [W-1:0] w_cnt_nxt;
  logic         w_last;
  logic         w_start;
  logic         w_new_clamp;
  logic [W-1:0] w_new_div;

  // floor(N/2) is H for both even and odd ratios
  assign w_half      = r_cur_div >> 1;
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_last      = (r_state == S_RUN) && (r_cnt == r_cur_div - 1'b1);
  assign w_start     = en && ((r_state == S_IDLE) || w_last);
  assign w_new_clamp = (div_n < MIN_N);
  assign w_new_div   = w_new_clamp ? MIN_N : div_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_q_pos   <= 1'b0;
      r_tick    <= 1'b0;
      r_cur_div <= DEF;
      r_clamp   <= 1'b0;
      r_odd     <= DEF[0];
    end else if (w_start) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_q_pos   <= 1'b1;
      r_tick    <= 1'b1;
      r_cur_div <= w_new_div;
      r_clamp   <= w_new_clamp;
      r_odd     <= w_new_div[0];
    end else if (w_last) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q_pos <= 1'b0;
      r_tick  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cnt   <= w_cnt_nxt;
      r_q_pos <= (w_cnt_nxt < w_half);
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
    end
  end

  // Half-cycle extension of the high phase for odd ratios
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_neg <= 1'b0;
    end else begin
      r_q_neg <= r_q_pos;
    end
  end

  assign div_clk  = r_q_pos | (r_q_neg & r_odd);
  assign div_tick = r_tick;
  assign cur_div  = r_cur_div;
  assign running  = (r_state == S_RUN);
  assign clamp    = r_clamp;

endmodule
